// File: rtl/stepdown_discharge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stepdown_discharge_ctrl
//  Purpose  : Enable / discharge sequencer for the step-down converter output.
//             On request the converter is enabled. On disable or undervoltage
//             the converter is switched off, a dead time elapses, then the
//             active-low discharge gate (NAND2 discharge cell input) is driven
//             until the output is sensed low or a timeout expires. A timeout
//             sets a sticky flag that blocks restart until it is cleared.
//  Ports    :
//    clk       in   system clock
//    rstn      in   asynchronous active-low reset
//    CELV      in   cell supply    (no functional effect)
//    CELG      in   cell ground    (no functional effect)
//    SUB       in   substrate      (no functional effect)
//    en_req    in   converter enable request, synchronous
//    uv_fault  in   undervoltage fault, synchronous level
//    vout_low  in   output-low comparator, asynchronous
//    clr_flag  in   one-cycle pulse, clears tmo_flag
//    sd_en     out  converter enable, registered
//    dis_n     out  discharge gate drive, active low, registered
//    busy      out  high while in DEAD or DISCH
//    tmo_flag  out  sticky discharge-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module stepdown_discharge_ctrl #(
  parameter int unsigned DEAD_CYC  = 4,
  parameter int unsigned DISCH_TMO = 1000,
  parameter int unsigned DEB_CYC   = 3,
  parameter int unsigned CNT_W     = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic en_req,
  input  logic uv_fault,
  input  logic vout_low,
  input  logic clr_flag,
  output logic sd_en,
  output logic dis_n,
  output logic busy,
  output logic tmo_flag
);

  // State encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [1:0] S_DISCH = 2'd3;

  // Terminal counts, sized to the shared counter
  localparam logic [CNT_W-1:0] C_DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] C_DISCH_LAST = CNT_W'(DISCH_TMO - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       C_DEB_THR    = 4'(DEB_CYC);

  // Supply / substrate pins only exist for netlist connectivity
  logic unused_pwr;
  assign unused_pwr = CELV ^ CELG ^ SUB;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sd_en_q, sd_en_d;
  logic             dis_n_q, dis_n_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             tmo_set;
  logic             sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic             vl_ok;

  // --------------------------------------------------------------------------
  // vout_low synchronizer and debounce
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 4'd0;
    end else begin
      sync1_q <= vout_low;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  // Count consecutive high samples; saturating at the threshold keeps vl_ok
  // asserted for as long as the input stays high.
  always_comb begin
    deb_d = 4'd0;
    if (sync2_q) begin
      if (deb_q >= C_DEB_THR) begin
        deb_d = deb_q;
      end else begin
        deb_d = deb_q + 4'd1;
      end
    end
  end

  assign vl_ok = (deb_q >= C_DEB_THR);

  // --------------------------------------------------------------------------
  // FSM: state register (with counter, outputs and flag)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sd_en_q    <= 1'b0;
      dis_n_q    <= 1'b1;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sd_en_q    <= sd_en_d;
      dis_n_q    <= dis_n_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en_req && !uv_fault && !tmo_flag_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!en_req || uv_fault) begin
          state_d = S_DEAD;
        end
      end
      S_DEAD: begin
        // >= rather than == so a corrupted count still leaves the state
        if (cnt_q >= C_DEAD_LAST) begin
          state_d = S_DISCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DISCH: begin
        // Sensed-low exit has priority over the timeout in the same cycle
        if (vl_ok) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= C_DISCH_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tmo_set = 1'b1;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // Registered outputs are decoded from the next state, so sd_en and dis_n
  // change on the same edge as the transition and can never overlap.
  // --------------------------------------------------------------------------
  always_comb begin
    sd_en_d    = (state_d == S_RUN);
    dis_n_d    = (state_d != S_DISCH);
    busy       = (state_q == S_DEAD) || (state_q == S_DISCH);
    // A timeout in the same cycle as a clear leaves the flag set
    tmo_flag_d = tmo_flag_q;
    if (tmo_set) begin
      tmo_flag_d = 1'b1;
    end else if (clr_flag) begin
      tmo_flag_d = 1'b0;
    end
  end

  assign sd_en    = sd_en_q;
  assign dis_n    = dis_n_q;
  assign tmo_flag = tmo_flag_q;

  // Converter enable and discharge must never be active together
  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
    !(sd_en_q && !dis_n_q));

endmodule
`default_nettype wire

// File: tb/tb_stepdown_discharge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stepdown_discharge_ctrl
//  Purpose  : Self-checking bench for stepdown_discharge_ctrl. Directed
//             sequences plus randomized traffic, compared every cycle with a
//             timeline-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stepdown_discharge_ctrl;

  localparam int DEAD_CYC  = 4;
  localparam int DISCH_TMO = 1000;
  localparam int DEB_CYC   = 3;
  localparam int CNT_W     = 12;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DEAD  = 2;
  localparam int PH_DISCH = 3;

  logic clk      = 1'b0;
  logic rstn     = 1'b0;
  logic CELV     = 1'b1;
  logic CELG     = 1'b0;
  logic SUB      = 1'b0;
  logic en_req   = 1'b0;
  logic uv_fault = 1'b0;
  logic vout_low = 1'b0;
  logic clr_flag = 1'b0;
  logic sd_en, dis_n, busy, tmo_flag;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: phase, remaining dead time, elapsed discharge
  // cycles, sticky flag, and the history of sampled vout_low values
  // (hist[0] = sample at the latest edge).
  int m_ph;
  int m_dead_left;
  int m_disch_n;
  int m_flag;
  int hist[0:19];

  stepdown_discharge_ctrl #(
    .DEAD_CYC (DEAD_CYC),
    .DISCH_TMO(DISCH_TMO),
    .DEB_CYC  (DEB_CYC),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .CELV    (CELV),
    .CELG    (CELG),
    .SUB     (SUB),
    .en_req  (en_req),
    .uv_fault(uv_fault),
    .vout_low(vout_low),
    .clr_flag(clr_flag),
    .sd_en   (sd_en),
    .dis_n   (dis_n),
    .busy    (busy),
    .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph        = PH_IDLE;
    m_dead_left = 0;
    m_disch_n   = 0;
    m_flag      = 0;
    for (int i = 0; i < 20; i++) hist[i] = 0;
  endtask

  // Output is "sensed low" when the DEB_CYC samples taken 3..(2+DEB_CYC)
  // edges ago were all high (two sync stages plus one debounce register).
  task automatic model_step(input logic en, input logic uv, input logic vl, input logic clr);
    int ok;
    int set;
    for (int i = 19; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(vl);
    ok = 1;
    for (int i = 3; i <= 2 + DEB_CYC; i++) if (hist[i] == 0) ok = 0;
    set = 0;
    case (m_ph)
      PH_IDLE: if (en && !uv && m_flag == 0) m_ph = PH_RUN;
      PH_RUN: if (!en || uv) begin
        m_ph        = PH_DEAD;
        m_dead_left = DEAD_CYC;
      end
      PH_DEAD: begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          m_ph      = PH_DISCH;
          m_disch_n = 0;
        end
      end
      default: begin
        m_disch_n++;
        if (ok != 0) m_ph = PH_IDLE;
        else if (m_disch_n == DISCH_TMO) begin
          m_ph = PH_IDLE;
          set  = 1;
        end
      end
    endcase
    if (set != 0) m_flag = 1;
    else if (clr) m_flag = 0;
  endtask

  // Drive inputs, take one clock edge, then compare every output to the model
  task automatic tick(input logic en, input logic uv, input logic vl, input logic clr);
    en_req   = en;
    uv_fault = uv;
    vout_low = vl;
    clr_flag = clr;
    @(posedge clk);
    model_step(en, uv, vl, clr);
    #1;
    check("sd_en",    int'(sd_en),    int'(m_ph == PH_RUN));
    check("dis_n",    int'(dis_n),    int'(m_ph != PH_DISCH));
    check("busy",     int'(busy),     int'(m_ph == PH_DEAD || m_ph == PH_DISCH));
    check("tmo_flag", int'(tmo_flag), m_flag);
    check("overlap",  int'(sd_en && !dis_n), 0);
  endtask

  // From IDLE: enable, disable, sit out the dead time; ends in DISCH
  task automatic go_disch();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (DEAD_CYC) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int   n;
    logic vl_r;

    // Reset state
    model_reset();
    #12;
    check("rst_sd_en", int'(sd_en), 0);
    check("rst_dis_n", int'(dis_n), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_tmo",   int'(tmo_flag), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Enable at cycle 3, one-cycle latency
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("en_latency", int'(sd_en), 1);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    #2 rstn = 1'b0;
    #1;
    check("async_rst_sd_en", int'(sd_en), 0);
    check("async_rst_dis_n", int'(dis_n), 1);
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;

    // Disable from RUN: dead time between sd_en fall and dis_n fall
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("sd_en_off", int'(sd_en), 0);
    n = 0;
    while (dis_n && n < 20) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("dead_time", n, DEAD_CYC);

    // Two-cycle glitch must not end the discharge
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("glitch_hold", int'(dis_n), 0);

    // Sustained vout_low: exit latency 2 + DEB_CYC + 1
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n = 1;
    while (!dis_n && n < 20) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check("vl_latency", n, 2 + DEB_CYC + 1);
    repeat (10 - n) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("vl_exit_flag", int'(tmo_flag), 0);

    // Timeout: discharge lasts exactly DISCH_TMO cycles, then restart lockout
    go_disch();
    n = 0;
    while (!dis_n && n < DISCH_TMO + 100) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("disch_len", n, DISCH_TMO);
    check("tmo_set", int'(tmo_flag), 1);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("lockout", int'(sd_en), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_same_cycle", int'(sd_en), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart", int'(sd_en), 1);

    // uv_fault shutdown with en_req held; en_req toggles ignored meanwhile
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("uv_off", int'(sd_en), 0);
    repeat (40) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      n++;
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Sensed-low and timeout on the same edge: normal exit
    go_disch();
    for (int k = 1; k <= DISCH_TMO; k++)
      tick(1'b0, 1'b0, 1'(k >= DISCH_TMO - 2 - DEB_CYC), 1'b0);
    check("tie_flag", int'(tmo_flag), 0);
    check("tie_dis_n", int'(dis_n), 1);

    // One cycle later: timeout wins
    go_disch();
    for (int k = 1; k <= DISCH_TMO; k++)
      tick(1'b0, 1'b0, 1'(k >= DISCH_TMO - 1 - DEB_CYC), 1'b0);
    check("late_vl_flag", int'(tmo_flag), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_flag", int'(tmo_flag), 0);

    // Clear and timeout on the same edge: set wins
    go_disch();
    for (int k = 1; k <= DISCH_TMO; k++)
      tick(1'b0, 1'b0, 1'b0, 1'(k == DISCH_TMO));
    check("set_over_clr", int'(tmo_flag), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    vl_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) vl_r = ~vl_r;
      tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0),
           vl_r, 1'($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
